branch_resolution_unit: RTL and testbench

- EX-stage consumer of IF-stage branch prediction metadata; the resolving end of the prediction protocol.
- Compares actual control-flow outcome against the registered prediction (used flag, predicted target) carried down the pipeline.
- On misprediction: generates the PC redirect and front-end flush, a post-redirect holdoff window, and a registered BTB update.
- Also emits saturating branch/mispredict performance counters.

---
 rtl/branch_resolution_pkg.sv | 19 +
 rtl/bru_sat_counter.sv | 25 ++
 rtl/branch_resolution_unit.sv | 164 ++++++++++++++++
 tb/tb_branch_resolution_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolution_pkg.sv
// Shared types for the branch resolution unit: FSM states, mispredict
// classes and the width of the post-redirect holdoff counter.
package branch_resolution_pkg;

    typedef enum logic {
        BRU_IDLE,
        BRU_HOLDOFF
    } bru_state_e;

    typedef enum logic [1:0] {
        MP_NONE,
        MP_MISS_TAKEN,
        MP_WRONG_TARGET,
        MP_FALSE_TAKEN
    } mispredict_e;

    localparam int HOLDOFF_W = 3;

endpackage

// File: rtl/bru_sat_counter.sv
// Saturating up-counter used for the branch/mispredict performance counters.
// Sticks at all-ones instead of wrapping.
module bru_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count enabled events, holding at the maximum value once reached.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/branch_resolution_unit.sv
// EX-stage branch resolution: checks the fetch-time prediction against the
// real outcome, redirects/flushes the front end on a mispredict, holds off
// further resolution while wrong-path instructions drain, writes the BTB and
// keeps performance counters.
module branch_resolution_unit
    import branch_resolution_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int HOLDOFF_CYCLES = 2,
    parameter int CNT_W          = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_valid,
    input  logic             i_is_branch,
    input  logic             i_is_jump,
    input  logic             i_cond_taken,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_target,
    input  logic [XLEN-1:0]  i_fallthrough,
    input  logic             i_pred_used,
    input  logic [XLEN-1:0]  i_pred_target,
    output logic             o_redirect,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic             o_flush,
    output logic             o_holdoff,
    output logic             o_btb_update,
    output logic [XLEN-1:0]  o_btb_update_pc,
    output logic [XLEN-1:0]  o_btb_update_target,
    output logic             o_btb_update_taken,
    output logic [CNT_W-1:0] o_branch_count,
    output logic [CNT_W-1:0] o_mispredict_count
);

    bru_state_e             r_state;
    bru_state_e             w_state_next;
    logic [HOLDOFF_W-1:0]   r_hold_cnt;
    logic [HOLDOFF_W-1:0]   w_hold_cnt_next;

    logic                   w_resolve;
    logic                   w_cf;
    logic                   w_actual_taken;
    logic                   w_btb_fire;
    mispredict_e            w_mp;
    logic                   w_redirect;
    logic [XLEN-1:0]        w_redirect_pc;

    logic                   r_btb_update;
    logic [XLEN-1:0]        r_btb_pc;
    logic [XLEN-1:0]        r_btb_target;
    logic                   r_btb_taken;

    // Only instructions seen in IDLE are on the correct path; HOLDOFF ones are discarded.
    assign w_resolve      = i_valid && !i_stall && (r_state == BRU_IDLE);
    assign w_cf           = i_is_branch || i_is_jump;
    assign w_actual_taken = i_is_jump || (i_is_branch && i_cond_taken);
    // Non-cf instructions with a prediction are BTB aliases and need the entry corrected too.
    assign w_btb_fire     = w_resolve && (w_cf || i_pred_used);

    // Classify the outcome and pick the redirect address.
    always_comb begin
        w_mp          = MP_NONE;
        w_redirect_pc = '0;
        if (w_resolve) begin
            if (w_actual_taken && !i_pred_used) begin
                w_mp = MP_MISS_TAKEN;
            end else if (w_actual_taken && (i_pred_target != i_target)) begin
                w_mp = MP_WRONG_TARGET;
            end else if (!w_actual_taken && i_pred_used) begin
                w_mp = MP_FALSE_TAKEN;
            end
        end
        case (w_mp)
            MP_MISS_TAKEN,
            MP_WRONG_TARGET: w_redirect_pc = i_target;
            MP_FALSE_TAKEN:  w_redirect_pc = i_fallthrough;
            default:         w_redirect_pc = '0;
        endcase
    end

    assign w_redirect    = (w_mp != MP_NONE);
    assign o_redirect    = w_redirect;
    assign o_flush       = w_redirect;
    assign o_redirect_pc = w_redirect_pc;

    // Holdoff FSM next state: count down unstalled cycles after a redirect.
    always_comb begin
        w_state_next    = r_state;
        w_hold_cnt_next = r_hold_cnt;
        case (r_state)
            BRU_IDLE: begin
                if (w_redirect) begin
                    w_state_next    = BRU_HOLDOFF;
                    w_hold_cnt_next = HOLDOFF_W'(HOLDOFF_CYCLES);
                end
            end
            BRU_HOLDOFF: begin
                if (!i_stall) begin
                    if (r_hold_cnt <= HOLDOFF_W'(1)) begin
                        w_state_next    = BRU_IDLE;
                        w_hold_cnt_next = '0;
                    end else begin
                        w_hold_cnt_next = r_hold_cnt - HOLDOFF_W'(1);
                    end
                end
            end
            default: begin
                w_state_next    = BRU_IDLE;
                w_hold_cnt_next = '0;
            end
        endcase
    end

    // Holdoff FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= BRU_IDLE;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_cnt_next;
        end
    end

    assign o_holdoff = (r_state == BRU_HOLDOFF);

    // BTB write register; the pulse is single-cycle even if a stall follows.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_btb_update <= 1'b0;
            r_btb_pc     <= '0;
            r_btb_target <= '0;
            r_btb_taken  <= 1'b0;
        end else begin
            r_btb_update <= w_btb_fire;
            if (w_btb_fire) begin
                r_btb_pc     <= i_pc;
                r_btb_target <= i_target;
                r_btb_taken  <= w_actual_taken;
            end
        end
    end

    assign o_btb_update        = r_btb_update;
    assign o_btb_update_pc     = r_btb_pc;
    assign o_btb_update_target = r_btb_target;
    assign o_btb_update_taken  = r_btb_taken;

    bru_sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (w_resolve && w_cf),
        .o_count (o_branch_count)
    );

    bru_sat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (w_redirect),
        .o_count (o_mispredict_count)
    );

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit. A second instance with 4-bit
// counters shares the inputs and is used for the saturation scenario.
module tb_branch_resolution_unit;

    logic        i_clk = 1'b0;
    logic        i_reset, i_stall, i_valid, i_is_branch, i_is_jump, i_cond_taken;
    logic [31:0] i_pc, i_target, i_fallthrough, i_pred_target;
    logic        i_pred_used;

    logic        o_redirect, o_flush, o_holdoff, o_btb_update, o_btb_update_taken;
    logic [31:0] o_redirect_pc, o_btb_update_pc, o_btb_update_target;
    logic [31:0] o_branch_count, o_mispredict_count;

    logic        s_redirect, s_flush, s_holdoff, s_btb_update, s_btb_update_taken;
    logic [31:0] s_redirect_pc, s_btb_update_pc, s_btb_update_target;
    logic [3:0]  s_branch_count, s_mispredict_count;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    branch_resolution_unit #(.XLEN(32), .HOLDOFF_CYCLES(2), .CNT_W(32)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_valid(i_valid),
        .i_is_branch(i_is_branch), .i_is_jump(i_is_jump), .i_cond_taken(i_cond_taken),
        .i_pc(i_pc), .i_target(i_target), .i_fallthrough(i_fallthrough),
        .i_pred_used(i_pred_used), .i_pred_target(i_pred_target),
        .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc), .o_flush(o_flush),
        .o_holdoff(o_holdoff), .o_btb_update(o_btb_update),
        .o_btb_update_pc(o_btb_update_pc), .o_btb_update_target(o_btb_update_target),
        .o_btb_update_taken(o_btb_update_taken),
        .o_branch_count(o_branch_count), .o_mispredict_count(o_mispredict_count)
    );

    branch_resolution_unit #(.XLEN(32), .HOLDOFF_CYCLES(2), .CNT_W(4)) dut4 (
        .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_valid(i_valid),
        .i_is_branch(i_is_branch), .i_is_jump(i_is_jump), .i_cond_taken(i_cond_taken),
        .i_pc(i_pc), .i_target(i_target), .i_fallthrough(i_fallthrough),
        .i_pred_used(i_pred_used), .i_pred_target(i_pred_target),
        .o_redirect(s_redirect), .o_redirect_pc(s_redirect_pc), .o_flush(s_flush),
        .o_holdoff(s_holdoff), .o_btb_update(s_btb_update),
        .o_btb_update_pc(s_btb_update_pc), .o_btb_update_target(s_btb_update_target),
        .o_btb_update_taken(s_btb_update_taken),
        .o_branch_count(s_branch_count), .o_mispredict_count(s_mispredict_count)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic br, input logic jp, input logic ct,
                          input logic [31:0] pc, input logic [31:0] tg, input logic [31:0] ft,
                          input logic pu, input logic [31:0] pt);
        i_valid = v; i_is_branch = br; i_is_jump = jp; i_cond_taken = ct;
        i_pc = pc; i_target = tg; i_fallthrough = ft; i_pred_used = pu; i_pred_target = pt;
    endtask

    task automatic set_idle();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        i_reset = 1'b1; i_stall = 1'b0; set_idle();
        tick(); tick();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_redirect !== 1'b0 || o_flush !== 1'b0 || o_redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect: redirect=%b flush=%b pc=%h expected 0/0/0", o_redirect, o_flush, o_redirect_pc); end
        checks++; if (o_holdoff !== 1'b0 || o_btb_update !== 1'b0 || o_btb_update_taken !== 1'b0) begin errors++; $display("FAIL reset_ctrl: holdoff=%b btb=%b taken=%b expected 0", o_holdoff, o_btb_update, o_btb_update_taken); end
        checks++; if (o_btb_update_pc !== 32'h0 || o_btb_update_target !== 32'h0) begin errors++; $display("FAIL reset_btb_data: pc=%h target=%h expected 0", o_btb_update_pc, o_btb_update_target); end
        checks++; if (o_branch_count !== 32'h0 || o_mispredict_count !== 32'h0) begin errors++; $display("FAIL reset_counts: br=%0d mp=%0d expected 0", o_branch_count, o_mispredict_count); end
    endtask

    task automatic test_miss_taken();
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h180, 32'h104, 1'b0, 32'h0);
        #1;
        checks++; if (o_redirect !== 1'b1 || o_flush !== 1'b1 || o_redirect_pc !== 32'h180) begin errors++; $display("FAIL miss_taken_redirect: redirect=%b flush=%b pc=%h expected 1/1/00000180", o_redirect, o_flush, o_redirect_pc); end
        tick(); set_idle();
        checks++; if (o_btb_update !== 1'b1 || o_btb_update_pc !== 32'h100 || o_btb_update_target !== 32'h180 || o_btb_update_taken !== 1'b1) begin errors++; $display("FAIL miss_taken_btb: upd=%b pc=%h tgt=%h taken=%b expected 1/100/180/1", o_btb_update, o_btb_update_pc, o_btb_update_target, o_btb_update_taken); end
        checks++; if (o_holdoff !== 1'b1 || o_mispredict_count !== 32'd1 || o_branch_count !== 32'd1) begin errors++; $display("FAIL miss_taken_state: holdoff=%b mp=%0d br=%0d expected 1/1/1", o_holdoff, o_mispredict_count, o_branch_count); end
        tick();
        checks++; if (o_holdoff !== 1'b1 || o_btb_update !== 1'b0) begin errors++; $display("FAIL miss_taken_hold2: holdoff=%b btb=%b expected 1/0", o_holdoff, o_btb_update); end
        tick();
        checks++; if (o_holdoff !== 1'b0) begin errors++; $display("FAIL miss_taken_hold_end: holdoff=%b expected 0", o_holdoff); end
    endtask

    task automatic test_correct_pred();
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h180, 32'h104, 1'b1, 32'h180);
        #1;
        checks++; if (o_redirect !== 1'b0 || o_redirect_pc !== 32'h0) begin errors++; $display("FAIL correct_redirect: redirect=%b pc=%h expected 0/0", o_redirect, o_redirect_pc); end
        tick(); set_idle();
        checks++; if (o_btb_update !== 1'b1 || o_btb_update_taken !== 1'b1 || o_btb_update_target !== 32'h180) begin errors++; $display("FAIL correct_btb: upd=%b taken=%b tgt=%h expected 1/1/180", o_btb_update, o_btb_update_taken, o_btb_update_target); end
        checks++; if (o_branch_count !== 32'd1 || o_mispredict_count !== 32'd0 || o_holdoff !== 1'b0) begin errors++; $display("FAIL correct_counts: br=%0d mp=%0d holdoff=%b expected 1/0/0", o_branch_count, o_mispredict_count, o_holdoff); end
        // Not-taken branch without prediction: nothing to redirect, BTB still trained.
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h120, 32'h1A0, 32'h124, 1'b0, 32'h0);
        #1;
        checks++; if (o_redirect !== 1'b0) begin errors++; $display("FAIL nt_redirect: redirect=%b expected 0", o_redirect); end
        tick(); set_idle();
        checks++; if (o_btb_update !== 1'b1 || o_btb_update_taken !== 1'b0 || o_btb_update_pc !== 32'h120 || o_branch_count !== 32'd2) begin errors++; $display("FAIL nt_btb: upd=%b taken=%b pc=%h br=%0d expected 1/0/120/2", o_btb_update, o_btb_update_taken, o_btb_update_pc, o_branch_count); end
    endtask

    task automatic test_wrong_target();
        do_reset();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h300, 32'h204, 1'b1, 32'h2F0);
        #1;
        checks++; if (o_redirect !== 1'b1 || o_redirect_pc !== 32'h300) begin errors++; $display("FAIL wrong_target_redirect: redirect=%b pc=%h expected 1/00000300", o_redirect, o_redirect_pc); end
        tick(); set_idle();
        checks++; if (o_btb_update_target !== 32'h300 || o_btb_update_taken !== 1'b1 || o_mispredict_count !== 32'd1) begin errors++; $display("FAIL wrong_target_btb: tgt=%h taken=%b mp=%0d expected 300/1/1", o_btb_update_target, o_btb_update_taken, o_mispredict_count); end
        tick(); tick();
    endtask

    task automatic test_false_taken();
        do_reset();
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h80, 32'h44, 1'b1, 32'h80);
        #1;
        checks++; if (o_redirect !== 1'b1 || o_redirect_pc !== 32'h44) begin errors++; $display("FAIL false_taken_redirect: redirect=%b pc=%h expected 1/00000044", o_redirect, o_redirect_pc); end
        tick(); set_idle();
        checks++; if (o_btb_update !== 1'b1 || o_btb_update_pc !== 32'h40 || o_btb_update_taken !== 1'b0) begin errors++; $display("FAIL false_taken_btb: upd=%b pc=%h taken=%b expected 1/40/0", o_btb_update, o_btb_update_pc, o_btb_update_taken); end
        checks++; if (o_branch_count !== 32'd0 || o_mispredict_count !== 32'd1) begin errors++; $display("FAIL false_taken_counts: br=%0d mp=%0d expected 0/1", o_branch_count, o_mispredict_count); end
        tick(); tick();
    endtask

    task automatic test_stall_idle();
        do_reset();
        i_stall = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h500, 32'h580, 32'h504, 1'b0, 32'h0);
        #1;
        checks++; if (o_redirect !== 1'b0) begin errors++; $display("FAIL stall_idle_redirect: redirect=%b expected 0", o_redirect); end
        tick();
        checks++; if (o_btb_update !== 1'b0 || o_branch_count !== 32'd0 || o_holdoff !== 1'b0) begin errors++; $display("FAIL stall_idle_state: btb=%b br=%0d holdoff=%b expected 0/0/0", o_btb_update, o_branch_count, o_holdoff); end
        i_stall = 1'b0;
        #1;
        checks++; if (o_redirect !== 1'b1 || o_redirect_pc !== 32'h580) begin errors++; $display("FAIL stall_release_redirect: redirect=%b pc=%h expected 1/00000580", o_redirect, o_redirect_pc); end
        tick(); set_idle();
        // Stall right after resolve: BTB pulse must still drop after one cycle.
        i_stall = 1'b1;
        checks++; if (o_btb_update !== 1'b1 || o_branch_count !== 32'd1) begin errors++; $display("FAIL stall_release_btb: btb=%b br=%0d expected 1/1", o_btb_update, o_branch_count); end
        tick();
        checks++; if (o_btb_update !== 1'b0 || o_holdoff !== 1'b1) begin errors++; $display("FAIL stall_btb_pulse: btb=%b holdoff=%b expected 0/1", o_btb_update, o_holdoff); end
        i_stall = 1'b0;
        tick(); tick();
    endtask

    task automatic test_holdoff_stall();
        int hcount;
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h180, 32'h104, 1'b0, 32'h0);
        tick();
        hcount = 0;
        // Wrong-path mispredicting branch held valid for the whole window.
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h104, 32'h900, 32'h108, 1'b0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            i_stall = (c >= 1 && c <= 3) ? 1'b1 : 1'b0;
            #1;
            if (o_holdoff === 1'b1) hcount++;
            checks++; if (o_redirect !== 1'b0) begin errors++; $display("FAIL holdoff_no_redirect c=%0d: redirect=%b expected 0", c, o_redirect); end
            tick();
        end
        i_stall = 1'b0;
        set_idle();
        checks++; if (hcount !== 5) begin errors++; $display("FAIL holdoff_len: high cycles=%0d expected 5", hcount); end
        checks++; if (o_holdoff !== 1'b0 || o_btb_update !== 1'b0) begin errors++; $display("FAIL holdoff_exit: holdoff=%b btb=%b expected 0/0", o_holdoff, o_btb_update); end
        checks++; if (o_mispredict_count !== 32'd1 || o_branch_count !== 32'd1) begin errors++; $display("FAIL holdoff_counts: mp=%0d br=%0d expected 1/1", o_mispredict_count, o_branch_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h50, 32'h14, 1'b1, 32'h50);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h14, 32'h70, 32'h18, 1'b0, 32'h0);
        #1;
        checks++; if (o_btb_update !== 1'b1 || o_btb_update_pc !== 32'h10 || o_redirect !== 1'b1 || o_redirect_pc !== 32'h70) begin errors++; $display("FAIL b2b_overlap: btb=%b pc=%h redirect=%b rpc=%h expected 1/10/1/70", o_btb_update, o_btb_update_pc, o_redirect, o_redirect_pc); end
        tick(); set_idle();
        checks++; if (o_btb_update !== 1'b1 || o_btb_update_pc !== 32'h14 || o_btb_update_target !== 32'h70 || o_branch_count !== 32'd2) begin errors++; $display("FAIL b2b_overwrite: btb=%b pc=%h tgt=%h br=%0d expected 1/14/70/2", o_btb_update, o_btb_update_pc, o_btb_update_target, o_branch_count); end
        tick(); tick();
    endtask

    task automatic test_saturation_and_reset();
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h180, 32'h104, 1'b0, 32'h0);
            tick(); set_idle();
            if (n == 15) begin
                checks++; if (s_mispredict_count !== 4'hF) begin errors++; $display("FAIL sat_15: mp=%h expected f", s_mispredict_count); end
            end
            if (n < 16) begin tick(); tick(); end
        end
        checks++; if (s_mispredict_count !== 4'hF || s_branch_count !== 4'hF) begin errors++; $display("FAIL sat_16: mp=%h br=%h expected f/f", s_mispredict_count, s_branch_count); end
        checks++; if (o_mispredict_count !== 32'd16) begin errors++; $display("FAIL wide_16: mp=%0d expected 16", o_mispredict_count); end
        checks++; if (o_holdoff !== 1'b1) begin errors++; $display("FAIL pre_reset_holdoff: holdoff=%b expected 1", o_holdoff); end
        i_reset = 1'b1;
        tick();
        checks++; if (o_holdoff !== 1'b0 || o_btb_update !== 1'b0 || o_redirect !== 1'b0 || s_holdoff !== 1'b0) begin errors++; $display("FAIL mid_hold_reset: holdoff=%b btb=%b redirect=%b s_holdoff=%b expected 0", o_holdoff, o_btb_update, o_redirect, s_holdoff); end
        checks++; if (o_mispredict_count !== 32'd0 || s_mispredict_count !== 4'h0 || o_btb_update_pc !== 32'h0) begin errors++; $display("FAIL mid_hold_reset_data: mp=%0d smp=%h pc=%h expected 0", o_mispredict_count, s_mispredict_count, o_btb_update_pc); end
        i_reset = 1'b0;
        // Back in IDLE straight away: a mispredict resolves immediately.
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h180, 32'h104, 1'b0, 32'h0);
        #1;
        checks++; if (o_redirect !== 1'b1) begin errors++; $display("FAIL post_reset_resolve: redirect=%b expected 1", o_redirect); end
        tick(); set_idle();
    endtask

    initial begin
        i_reset = 1'b1; i_stall = 1'b0;
        set_idle();
        test_reset();
        test_miss_taken();
        test_correct_pred();
        test_wrong_target();
        test_false_taken();
        test_stall_idle();
        test_holdoff_stall();
        test_back_to_back();
        test_saturation_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
